ft_sequencer: RTL and testbench
===============================

FT_SEQUENCER -- requirements
Module: ft_sequencer

Interface
REQ-001 SHALL have parameter DIV_BASE_LOG2, default 2, giving the log2 of the minimum step period in clocks.
REQ-002 SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_f  input  1  one-cycle request to start the Fibonacci generator.
REQ-005 SHALL have port start_t  input  1  one-cycle request to start the timer generator.
REQ-006 SHALL have port stop_f_t  input  1  one-cycle request to stop whichever generator runs.
REQ-007 SHALL have port update  input  1  one-cycle strobe that loads prog.
REQ-008 SHALL have port prog  input  3  speed code, sampled only with update.
REQ-009 SHALL have port gen_done  input  1  active generator reached its terminal value.
REQ-010 SHALL have port fifo_full  input  1  downstream backpressure; no step is issued while high.
REQ-011 SHALL have port clr_gen  output  1  one-cycle clear pulse to the selected generator.
REQ-012 SHALL have port step  output  1  one-cycle advance pulse to the selected generator.
REQ-013 SHALL have port sel_t  output  1  0 selects Fibonacci, 1 selects timer.
REQ-014 SHALL have port LED  output  6  one-hot state: [0]IDLE [1]CLR_F [2]CLR_T [3]RUN_F [4]RUN_T [5]STALL.

Function
REQ-015 SHALL implement states IDLE, CLR_F, CLR_T, RUN_F, RUN_T, STALL; LED equals the one-hot encoding of the current state.
REQ-016 SHALL, in IDLE, go to CLR_F on start_f or to CLR_T on start_t; if both are asserted in the same cycle, start_f wins.
REQ-017 SHALL assert clr_gen for exactly the single cycle spent in CLR_F/CLR_T, set sel_t (0 for CLR_F, 1 for CLR_T), clear div_cnt, then enter RUN_F/RUN_T.
REQ-018 SHALL hold step period P = 2^(DIV_BASE_LOG2+prog_reg) clocks (4..512 at default); div_cnt is 9 bits, increments in RUN_x, and wraps to 0 at P-1.
REQ-019 SHALL pulse step in the RUN_x cycle where div_cnt == P-1 and fifo_full == 0; the first step occurs P cycles after leaving CLR_x.
REQ-020 SHALL, if fifo_full == 1 when div_cnt == P-1, withhold step, freeze div_cnt at P-1, and enter STALL.
REQ-021 SHALL, in STALL, issue step in the first cycle fifo_full == 0, reset div_cnt to 0, and return to RUN_F/RUN_T according to sel_t.
REQ-022 SHALL return to IDLE on stop_f_t or gen_done in any RUN_x/STALL state; stop has priority over a coincident step, and step is suppressed in that cycle.
REQ-023 SHALL ignore start_f/start_t outside IDLE and ignore stop_f_t in IDLE/CLR_x.
REQ-024 SHALL load prog into prog_reg on update when in IDLE; an update outside IDLE is latched as pending (last value wins) and applied on the cycle of entry to IDLE.
REQ-025 SHALL hold sel_t unchanged in IDLE (last generator stays selected for display).

Reset
REQ-026 SHALL, on reset, immediately force state IDLE, LED=6'b000001, clr_gen=0, step=0, sel_t=0, div_cnt=0, prog_reg=0, and pending cleared.
REQ-027 SHALL abort any run in progress when reset is asserted mid-operation, with no step or clr_gen pulse emitted during or in the first cycle after reset.

Structure
REQ-028 SHALL place the state enumeration, LED one-hot encodings, and DIV_BASE_LOG2 default in the shared project package.
REQ-029 SHALL implement the period counter as one sub-module, step_divider (inputs: clear, run, hold, 3-bit code; output: terminal).

Verification
REQ-030 SHALL cover reset, update prog=3 in IDLE, then start_f -> one clr_gen, LED=RUN_F, step every 32 cycles, first step 32 cycles after CLR_F.
REQ-031 SHALL cover start_f and start_t asserted in the same cycle -> CLR_F, sel_t=0; start_t while in RUN_F -> no effect.
REQ-032 SHALL cover prog=0, fifo_full held high for 10 cycles across a terminal count -> LED=STALL, no step; one step on the first cycle low, then RUN_x.
REQ-033 SHALL cover update prog=5 during RUN_T -> period stays unchanged; after stop_f_t, IDLE, and start_f -> period is 128.
REQ-034 SHALL cover stop_f_t coinciding with a terminal count -> no step, IDLE next cycle; gen_done -> IDLE.
REQ-035 SHALL cover reset asserted mid-RUN_T -> all outputs at reset values immediately; no pulses after release until a new start.

Source files
------------

// File: rtl/ft_sequencer_pkg.sv
// rtl/ft_sequencer_pkg.sv - shared state encodings and period helper for ft_sequencer
package ft_sequencer_pkg;

    localparam int DIV_BASE_LOG2_DEFAULT = 2;

    typedef logic [5:0] state_t;

    // One-hot state codes; the LED output shows the state register directly
    localparam state_t ST_IDLE  = 6'b000001;
    localparam state_t ST_CLR_F = 6'b000010;
    localparam state_t ST_CLR_T = 6'b000100;
    localparam state_t ST_RUN_F = 6'b001000;
    localparam state_t ST_RUN_T = 6'b010000;
    localparam state_t ST_STALL = 6'b100000;

    // Terminal count (P-1) for a step period of 2^(base+code) clocks
    function automatic logic [8:0] period_last(input int base, input logic [2:0] code);
        logic [9:0] p;
        logic [9:0] m;
        p = 10'd1 << (base + int'(code));
        m = p - 10'd1;
        return m[8:0];
    endfunction

endpackage

// File: rtl/ft_sequencer_step_divider.sv
// rtl/ft_sequencer_step_divider.sv - programmable step-period counter
module step_divider
    import ft_sequencer_pkg::*;
#(
    parameter int DIV_BASE_LOG2 = DIV_BASE_LOG2_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
    input  logic       hold,
    input  logic [2:0] code,
    output logic       terminal
);

    logic [8:0] div_cnt;
    logic [8:0] last;

    assign last     = period_last(DIV_BASE_LOG2, code);
    assign terminal = (div_cnt == last);

    // Count while running; hold only freezes the counter once it sits at terminal
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= 9'd0;
        end else if (clear) begin
            div_cnt <= 9'd0;
        end else if (run) begin
            if (terminal) begin
                if (!hold) begin
                    div_cnt <= 9'd0;
                end
            end else begin
                div_cnt <= div_cnt + 9'd1;
            end
        end
    end

endmodule

// File: rtl/ft_sequencer.sv
// rtl/ft_sequencer.sv - Fibonacci/timer generator sequencer with paced steps and backpressure
module ft_sequencer
    import ft_sequencer_pkg::*;
#(
    parameter int DIV_BASE_LOG2 = DIV_BASE_LOG2_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_f,
    input  logic       start_t,
    input  logic       stop_f_t,
    input  logic       update,
    input  logic [2:0] prog,
    input  logic       gen_done,
    input  logic       fifo_full,
    output logic       clr_gen,
    output logic       step,
    output logic       sel_t,
    output logic [5:0] LED
);

    state_t     state;
    state_t     next_state;
    logic [2:0] prog_reg;
    logic [2:0] pend_val;
    logic       pend_valid;
    logic       terminal;
    logic       active;
    logic       stopping;

    assign active   = (state == ST_RUN_F) || (state == ST_RUN_T) || (state == ST_STALL);
    assign stopping = active && (stop_f_t || gen_done);
    assign clr_gen  = (state == ST_CLR_F) || (state == ST_CLR_T);
    assign step     = active && terminal && !fifo_full && !stopping;
    assign LED      = state;

    step_divider #(
        .DIV_BASE_LOG2(DIV_BASE_LOG2)
    ) u_div (
        .clock   (clock),
        .reset   (reset),
        .clear   (clr_gen),
        .run     (active && !stopping),
        .hold    (fifo_full),
        .code    (prog_reg),
        .terminal(terminal)
    );

    // Next-state decode; start_f beats start_t, stop/gen_done beat a pending step
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_f) begin
                    next_state = ST_CLR_F;
                end else if (start_t) begin
                    next_state = ST_CLR_T;
                end
            end
            ST_CLR_F: next_state = ST_RUN_F;
            ST_CLR_T: next_state = ST_RUN_T;
            ST_RUN_F, ST_RUN_T: begin
                if (stopping) begin
                    next_state = ST_IDLE;
                end else if (terminal && fifo_full) begin
                    next_state = ST_STALL;
                end
            end
            ST_STALL: begin
                if (stopping) begin
                    next_state = ST_IDLE;
                end else if (!fifo_full) begin
                    next_state = sel_t ? ST_RUN_T : ST_RUN_F;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Generator select changes only when a new run begins, so IDLE keeps the last one shown
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_t <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (next_state == ST_CLR_F) begin
                sel_t <= 1'b0;
            end else if (next_state == ST_CLR_T) begin
                sel_t <= 1'b1;
            end
        end
    end

    // Speed code: direct load in IDLE, otherwise deferred until the run ends
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prog_reg   <= 3'd0;
            pend_val   <= 3'd0;
            pend_valid <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (update) begin
                prog_reg <= prog;
            end
        end else if (next_state == ST_IDLE) begin
            if (update) begin
                prog_reg <= prog;
            end else if (pend_valid) begin
                prog_reg <= pend_val;
            end
            pend_valid <= 1'b0;
        end else if (update) begin
            pend_val   <= prog;
            pend_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ft_sequencer.sv
// tb/tb_ft_sequencer.sv - directed self-checking bench for ft_sequencer
module tb_ft_sequencer;

    logic       clock;
    logic       reset;
    logic       start_f;
    logic       start_t;
    logic       stop_f_t;
    logic       update;
    logic [2:0] prog;
    logic       gen_done;
    logic       fifo_full;
    logic       clr_gen;
    logic       step;
    logic       sel_t;
    logic [5:0] LED;

    int n_cmp;
    int n_bad;
    int clr_seen;
    int step_seen;
    int n;

    ft_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .start_f  (start_f),
        .start_t  (start_t),
        .stop_f_t (stop_f_t),
        .update   (update),
        .prog     (prog),
        .gen_done (gen_done),
        .fifo_full(fifo_full),
        .clr_gen  (clr_gen),
        .step     (step),
        .sel_t    (sel_t),
        .LED      (LED)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; all sampling and driving happens 3 time units after the edge
    task automatic tick();
        @(posedge clock);
        #3;
        if (step === 1'b1) step_seen++;
        if (clr_gen === 1'b1) clr_seen++;
    endtask

    // Cycles until the next step pulse, -1 if none within the bound
    task automatic wait_step(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 1100; i++) begin
            @(posedge clock);
            #3;
            if (clr_gen === 1'b1) clr_seen++;
            if (step === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; clr_seen = 0; step_seen = 0;
        reset = 1'b1; start_f = 0; start_t = 0; stop_f_t = 0;
        update = 0; prog = 3'd0; gen_done = 0; fifo_full = 0;
        tick(); tick();
        chk("rst_led",  32'(LED),     32'h01);
        chk("rst_clr",  32'(clr_gen), 32'd0);
        chk("rst_step", 32'(step),    32'd0);
        chk("rst_sel",  32'(sel_t),   32'd0);
        reset = 1'b0;
        tick();

        // prog=3 -> P=32
        update = 1; prog = 3'd3; tick(); update = 0;
        start_f = 1; tick(); start_f = 0;
        chk("clrf_led", 32'(LED),     32'h02);
        chk("clrf_clr", 32'(clr_gen), 32'd1);
        chk("clrf_sel", 32'(sel_t),   32'd0);
        clr_seen = 0;
        wait_step(n);
        chk("p32_first", 32'(n), 32'd32);
        chk("runf_led", 32'(LED), 32'h08);
        wait_step(n);
        chk("p32_second", 32'(n), 32'd32);
        chk("p32_noclr", 32'(clr_seen), 32'd0);

        // both starts together -> Fibonacci; start_t while running ignored
        stop_f_t = 1; tick(); stop_f_t = 0;
        chk("stop_idle", 32'(LED), 32'h01);
        start_f = 1; start_t = 1; tick(); start_f = 0; start_t = 0;
        chk("both_led", 32'(LED),   32'h02);
        chk("both_sel", 32'(sel_t), 32'd0);
        tick();
        start_t = 1; tick(); start_t = 0;
        chk("start_t_ign", 32'(LED), 32'h08);
        chk("start_t_sel", 32'(sel_t), 32'd0);

        // prog=0, backpressure across terminal count
        stop_f_t = 1; tick(); stop_f_t = 0;
        update = 1; prog = 3'd0; tick(); update = 0;
        start_f = 1; tick(); start_f = 0;
        fifo_full = 1; step_seen = 0;
        repeat (10) tick();
        chk("stall_led",   32'(LED),       32'h20);
        chk("stall_nostep", 32'(step_seen), 32'd0);
        fifo_full = 0; #1;
        chk("stall_release_step", 32'(step), 32'd1);
        tick();
        chk("stall_back_run", 32'(LED),  32'h08);
        chk("stall_back_step", 32'(step), 32'd0);
        wait_step(n);
        chk("stall_next_step", 32'(n), 32'd3);

        // update during RUN_T is deferred
        stop_f_t = 1; tick(); stop_f_t = 0;
        start_t = 1; tick(); start_t = 0;
        chk("clrt_led", 32'(LED),     32'h04);
        chk("clrt_clr", 32'(clr_gen), 32'd1);
        chk("clrt_sel", 32'(sel_t),   32'd1);
        tick();
        update = 1; prog = 3'd5; tick(); update = 0;
        wait_step(n);
        chk("defer_first", 32'(n), 32'd2);
        wait_step(n);
        chk("defer_period", 32'(n), 32'd4);
        chk("runt_led", 32'(LED), 32'h10);
        stop_f_t = 1; tick(); stop_f_t = 0;
        chk("idle_led",  32'(LED),   32'h01);
        chk("idle_sel_hold", 32'(sel_t), 32'd1);
        start_f = 1; tick(); start_f = 0;
        wait_step(n);
        chk("p128_first", 32'(n), 32'd128);
        wait_step(n);
        chk("p128_second", 32'(n), 32'd128);

        // stop coinciding with terminal count
        repeat (128) tick();
        chk("term_step", 32'(step), 32'd1);
        stop_f_t = 1; #1;
        chk("stop_term_nostep", 32'(step), 32'd0);
        tick(); stop_f_t = 0;
        chk("stop_term_idle", 32'(LED), 32'h01);

        // gen_done ends a run
        start_t = 1; tick(); start_t = 0;
        tick();
        chk("gd_run", 32'(LED), 32'h10);
        gen_done = 1; tick(); gen_done = 0;
        chk("gd_idle", 32'(LED), 32'h01);

        // reset mid RUN_T
        start_t = 1; tick(); start_t = 0;
        repeat (5) tick();
        chk("pre_rst_led", 32'(LED), 32'h10);
        reset = 1; #1;
        chk("mid_rst_led",  32'(LED),     32'h01);
        chk("mid_rst_sel",  32'(sel_t),   32'd0);
        chk("mid_rst_clr",  32'(clr_gen), 32'd0);
        chk("mid_rst_step", 32'(step),    32'd0);
        tick(); tick();
        reset = 0;
        step_seen = 0; clr_seen = 0;
        repeat (600) tick();
        chk("post_rst_steps", 32'(step_seen), 32'd0);
        chk("post_rst_clrs",  32'(clr_seen),  32'd0);
        chk("post_rst_led",   32'(LED),       32'h01);
        start_f = 1; tick(); start_f = 0;
        chk("restart_clr", 32'(clr_gen), 32'd1);
        wait_step(n);
        chk("restart_p4", 32'(n), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
